tlul_host_adapter: RTL and testbench
====================================

# tlul_host_adapter

Bridges the CPU load/store port to a TileLink-UL channel A/D link, sitting directly upstream of TL-UL slaves such as the GPIO block. Accepts one simple request at a time, encodes it as Get, PutFullData or PutPartialData, waits for the channel D response, and returns read data plus an error flag to the CPU. Only one transaction is outstanding at a time. A watchdog bounds the wait for channel D.

## Interface
Parameters:
- SOURCE_ID, 1'b0, value driven on tl_a_source and expected back on tl_d_source
- TIMEOUT_CYCLES, 255, maximum cycles spent in D_WAIT before the transaction is abandoned with an error; must be ≥ 1

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- req_valid  in  1  CPU request valid
- req_ready  out  1  adapter can accept a request (IDLE only)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_size  in  2  log2 bytes (0/1/2); 3 is illegal
- req_wdata  in  32  write data, lane-aligned
- req_wmask  in  4  write byte lanes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data, lane-aligned and unshifted
- rsp_err  out  1  response carries an error (qualified by rsp_valid)
- tl_a_opcode/param/size  out  3/3/3  channel A fields
- tl_a_source  out  1
- tl_a_address  out  32
- tl_a_mask  out  4
- tl_a_data  out  32
- tl_a_corrupt  out  1  always 0
- tl_a_valid  out  1
- tl_a_ready  in  1
- tl_d_opcode/param/size  in  3/2/3
- tl_d_source/sink  in  1/1
- tl_d_denied/corrupt  in  1/1
- tl_d_data  in  32
- tl_d_valid  in  1
- tl_d_ready  out  1

## Operation
- States: IDLE, A_SEND, D_WAIT, RESP.
- IDLE: req_ready=1; tl_d_ready=1, so stray D beats are drained and discarded.
- On req_valid:
  - Misaligned request (addr not aligned to 2^size) or size=3 → go to RESP with err=1. No bus traffic is issued.
  - Otherwise register all A fields and go to A_SEND.
- Opcode encoding:
  - Read → Get (4).
  - Write with req_wmask equal to the size-aligned full mask → PutFullData (0).
  - Any other write → PutPartialData (1), with mask = req_wmask & aligned mask.
- Aligned mask: size 2 → 1111; size 1 → 0011<<addr[1]*2; size 0 → 0001<<addr[1:0].
- tl_a_mask for Get = aligned mask. tl_a_param = 0. tl_a_size = req_size zero-extended.
- A_SEND: tl_a_valid=1, fields stable until tl_a_ready; tl_d_ready=1.
  - A fire alone → D_WAIT.
  - A fire and D fire in the same cycle → RESP.
- D_WAIT: tl_d_ready=1; watchdog counts every cycle.
  - D fire → RESP.
  - Count reaches TIMEOUT_CYCLES → RESP with err=1.
- D checks; any failure sets err:
  - opcode must be AccessAckData(1) for Get, AccessAck(0) for Puts
  - param must be 0
  - size must equal the request size
  - source must equal SOURCE_ID
  - denied=0 and corrupt=0
- Read data is latched from tl_d_data on D fire. It is 0 on error-before-bus and on timeout.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no CPU backpressure.

## Timing
- Reset values: state IDLE; tl_a_valid=0; tl_d_ready=0 during reset; req_ready=0 during reset; rsp_valid=0; rsp_err=0; rsp_rdata=0; all A fields 0; watchdog=0.
- Best-case latency, cycle numbers relative to the request:
  - request accepted in cycle 0
  - tl_a_valid in cycle 1
  - with a_ready=1, a slave that responds one cycle later gives D fire in cycle 2
  - rsp_valid in cycle 3
- An illegal request gives rsp_valid in cycle 1.
- tl_a_valid never deasserts before the handshake.
- Reset asserted mid-transaction: next edge returns to IDLE with all outputs at reset values. A late D beat for the abandoned transaction is drained in IDLE and does not produce rsp_valid.
- The watchdog clears on entry to D_WAIT.

## Structure
- TL opcode/param constants go in the shared TL defines header: Get, PutFullData, PutPartialData, AccessAck, AccessAckData, params 0. The state enum is local.
- Natural sub-module: tlul_a_encode, combinational aligned-mask, opcode and misalignment logic. It is reusable by future TL masters.
- The state machine and watchdog stay in tlul_host_adapter.

## Test plan
- Word write 0x41 to 0x4, mask 1111, slave acks next cycle → A: opcode 0, size 2, mask 1111; rsp_valid in cycle 3, err=0.
- Byte write 0xAB to 0x6, size 0, wmask 0100 → PutPartialData? No: the mask equals the aligned mask, so PutFullData with mask 0100. Then wmask 0000 at size 2 → PutPartialData with mask 0000.
- Word read 0x0, slave returns AccessAckData data 0x0000000F → rsp_rdata=0x0000000F, err=0. Then read response with denied=1 → err=1.
- Halfword read at 0x3 → no tl_a_valid, rsp_valid in cycle 1 with err=1.
- Slave holds a_ready=0 for 5 cycles → A fields stable throughout; then never sends D → rsp_err=1 exactly TIMEOUT_CYCLES cycles after entering D_WAIT. A later D beat is drained without producing rsp_valid.
- Reset pulled low while in D_WAIT → next edge: tl_a_valid=0, rsp_valid=0, state IDLE; a new request after reset completes normally.

Source files
------------

// File: rtl/tlul_host_adapter_pkg.sv
// Shared TL-UL constants and lane-mask helpers used by TL-UL masters.
package tlul_host_adapter_pkg;

    // Channel A opcodes
    localparam logic [2:0] TlGet            = 3'd4;
    localparam logic [2:0] TlPutFullData    = 3'd0;
    localparam logic [2:0] TlPutPartialData = 3'd1;

    // Channel D opcodes
    localparam logic [2:0] TlAccessAck      = 3'd0;
    localparam logic [2:0] TlAccessAckData  = 3'd1;

    // Params are always zero for TL-UL
    localparam logic [2:0] TlAParamNone     = 3'd0;
    localparam logic [1:0] TlDParamNone     = 2'd0;

    // Byte lanes covered by a naturally aligned access of 2^size bytes.
    function automatic logic [3:0] aligned_mask(input logic [1:0] size,
                                                input logic [1:0] lsb);
        case (size)
            2'd0:    return 4'b0001 << lsb;
            2'd1:    return 4'b0011 << {lsb[1], 1'b0};
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Size 3 is never legal on a 32-bit bus.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lsb);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lsb[0];
            2'd2:    return |lsb;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/tlul_a_encode.sv
// Combinational channel A encoder: opcode, byte mask and legality of a CPU request.
module tlul_a_encode
    import tlul_host_adapter_pkg::*;
(
    input  logic       we,
    input  logic [1:0] addr_lsb,
    input  logic [1:0] size,
    input  logic [3:0] wmask,
    output logic [2:0] opcode,
    output logic [3:0] mask,
    output logic       illegal
);

    logic [3:0] full_mask;

    // Reads use the whole aligned lane set; writes narrow to PutPartialData
    // whenever the CPU mask does not cover exactly the aligned lanes.
    always_comb begin
        full_mask = aligned_mask(size, addr_lsb);
        illegal   = misaligned(size, addr_lsb);
        opcode    = TlGet;
        mask      = full_mask;
        if (we) begin
            if (wmask == full_mask) begin
                opcode = TlPutFullData;
                mask   = full_mask;
            end else begin
                opcode = TlPutPartialData;
                mask   = wmask & full_mask;
            end
        end
    end

endmodule

// File: rtl/tlul_host_adapter.sv
// Single-outstanding CPU load/store to TL-UL host bridge with a channel D watchdog.
module tlul_host_adapter
    import tlul_host_adapter_pkg::*;
#(
    parameter logic        SOURCE_ID      = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  tl_a_opcode,
    output logic [2:0]  tl_a_param,
    output logic [2:0]  tl_a_size,
    output logic        tl_a_source,
    output logic [31:0] tl_a_address,
    output logic [3:0]  tl_a_mask,
    output logic [31:0] tl_a_data,
    output logic        tl_a_corrupt,
    output logic        tl_a_valid,
    input  logic        tl_a_ready,
    input  logic [2:0]  tl_d_opcode,
    input  logic [1:0]  tl_d_param,
    input  logic [2:0]  tl_d_size,
    input  logic        tl_d_source,
    input  logic        tl_d_sink,
    input  logic        tl_d_denied,
    input  logic        tl_d_corrupt,
    input  logic [31:0] tl_d_data,
    input  logic        tl_d_valid,
    output logic        tl_d_ready
);

    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StASend, StDWait, StResp} state_e;

    state_e         state_q, state_d;
    logic [2:0]     a_opcode_q, a_opcode_d;
    logic [2:0]     a_size_q, a_size_d;
    logic [31:0]    a_address_q, a_address_d;
    logic [3:0]     a_mask_q, a_mask_d;
    logic [31:0]    a_data_q, a_data_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;

    logic [2:0]     enc_opcode;
    logic [3:0]     enc_mask;
    logic           enc_illegal;
    logic [2:0]     exp_d_opcode;
    logic           d_bad;
    logic           unused_sink;

    assign unused_sink = tl_d_sink;

    tlul_a_encode u_a_encode (
        .we       (req_we),
        .addr_lsb (req_addr[1:0]),
        .size     (req_size),
        .wmask    (req_wmask),
        .opcode   (enc_opcode),
        .mask     (enc_mask),
        .illegal  (enc_illegal)
    );

    assign tl_a_opcode  = a_opcode_q;
    assign tl_a_param   = TlAParamNone;
    assign tl_a_size    = a_size_q;
    assign tl_a_source  = SOURCE_ID;
    assign tl_a_address = a_address_q;
    assign tl_a_mask    = a_mask_q;
    assign tl_a_data    = a_data_q;
    assign tl_a_corrupt = 1'b0;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;

    // Validate the channel D beat against the outstanding request.
    always_comb begin
        exp_d_opcode = (a_opcode_q == TlGet) ? TlAccessAckData : TlAccessAck;
        d_bad = (tl_d_opcode != exp_d_opcode) || (tl_d_param != TlDParamNone) ||
                (tl_d_size != a_size_q) || (tl_d_source != SOURCE_ID) ||
                tl_d_denied || tl_d_corrupt;
    end

    // Next-state, datapath capture and handshake outputs.
    always_comb begin
        state_d     = state_q;
        a_opcode_d  = a_opcode_q;
        a_size_d    = a_size_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        wd_d        = wd_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        req_ready   = 1'b0;
        tl_a_valid  = 1'b0;
        tl_d_ready  = 1'b0;
        rsp_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready  = 1'b1;
                // Stray or late D beats are accepted and dropped here.
                tl_d_ready = 1'b1;
                if (req_valid) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (enc_illegal) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        a_opcode_d  = enc_opcode;
                        a_size_d    = {1'b0, req_size};
                        a_address_d = req_addr;
                        a_mask_d    = enc_mask;
                        a_data_d    = req_wdata;
                        state_d     = StASend;
                    end
                end
            end
            StASend: begin
                tl_a_valid = 1'b1;
                tl_d_ready = 1'b1;
                if (tl_a_ready) begin
                    if (tl_d_valid) begin
                        err_d   = d_bad;
                        rdata_d = tl_d_data;
                        state_d = StResp;
                    end else begin
                        wd_d    = '0;
                        state_d = StDWait;
                    end
                end
            end
            StDWait: begin
                tl_d_ready = 1'b1;
                wd_d       = wd_q + WdW'(1);
                // A real response wins over a coincident timeout.
                if (tl_d_valid) begin
                    err_d   = d_bad;
                    rdata_d = tl_d_data;
                    state_d = StResp;
                end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!rst) begin
            req_ready  = 1'b0;
            tl_d_ready = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            a_opcode_q  <= '0;
            a_size_q    <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_opcode_q  <= a_opcode_d;
            a_size_q    <= a_size_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Scoreboard bench for tlul_host_adapter with a scripted TL-UL slave.
module tb_tlul_host_adapter;

    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [2:0]  tl_a_opcode, tl_a_param, tl_a_size;
    logic        tl_a_source, tl_a_corrupt, tl_a_valid, tl_a_ready;
    logic [31:0] tl_a_address, tl_a_data;
    logic [3:0]  tl_a_mask;
    logic [2:0]  tl_d_opcode, tl_d_size;
    logic [1:0]  tl_d_param;
    logic        tl_d_source, tl_d_sink, tl_d_denied, tl_d_corrupt, tl_d_valid, tl_d_ready;
    logic [31:0] tl_d_data;

    tlul_host_adapter #(.SOURCE_ID(1'b0), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .tl_a_opcode(tl_a_opcode), .tl_a_param(tl_a_param), .tl_a_size(tl_a_size),
        .tl_a_source(tl_a_source), .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask),
        .tl_a_data(tl_a_data), .tl_a_corrupt(tl_a_corrupt), .tl_a_valid(tl_a_valid),
        .tl_a_ready(tl_a_ready),
        .tl_d_opcode(tl_d_opcode), .tl_d_param(tl_d_param), .tl_d_size(tl_d_size),
        .tl_d_source(tl_d_source), .tl_d_sink(tl_d_sink), .tl_d_denied(tl_d_denied),
        .tl_d_corrupt(tl_d_corrupt), .tl_d_data(tl_d_data), .tl_d_valid(tl_d_valid),
        .tl_d_ready(tl_d_ready)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } a_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned acc_cyc;
    } rsp_exp_t;

    typedef struct {
        int          a_delay;
        int          d_delay;   // -1: D beat in the same cycle as the A handshake
        bit          no_d;
        bit          late;
        int          late_gap;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [2:0]  d_size;
        logic        d_source;
        logic        d_denied;
        logic        d_corrupt;
        logic [31:0] d_data;
    } plan_t;

    a_exp_t   exp_a_q[$];
    rsp_exp_t exp_rsp_q[$];
    plan_t    plan_q[$];
    bit       slave_busy = 1'b0;
    int       n_checks = 0;
    int       n_pass = 0;
    int       n_rsp = 0;
    int       n_rsp_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic plan_t good_plan(input bit we, input logic [1:0] size, input int a_dly,
                                        input int d_dly, input logic [31:0] data);
        plan_t p;
        p.a_delay   = a_dly;
        p.d_delay   = d_dly;
        p.no_d      = 1'b0;
        p.late      = 1'b0;
        p.late_gap  = 0;
        p.d_opcode  = we ? 3'd0 : 3'd1;
        p.d_param   = 2'd0;
        p.d_size    = {1'b0, size};
        p.d_source  = 1'b0;
        p.d_denied  = 1'b0;
        p.d_corrupt = 1'b0;
        p.d_data    = data;
        return p;
    endfunction

    // Reference model: derive A fields and the response from TL-UL rules, then drive the request.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [3:0] wmask, input plan_t p,
                         input bit expect_rsp);
        int unsigned nbytes = 1 << size;
        int unsigned lane   = addr % 4;
        bit          illegal = (size == 2'd3) || ((addr % nbytes) != 0);
        logic [3:0]  full   = 4'((((1 << nbytes) - 1) << lane) & 15);
        a_exp_t      a;
        rsp_exp_t    r;
        int          k;
        bit          bad;
        if (illegal) begin
            r.err = 1'b1; r.rdata = 32'h0; r.lat = 1;
        end else begin
            a.addr = addr; a.size = {1'b0, size}; a.data = wdata;
            if (!we)                begin a.opcode = 3'd4; a.mask = full; end
            else if (wmask == full) begin a.opcode = 3'd0; a.mask = full; end
            else                    begin a.opcode = 3'd1; a.mask = wmask & full; end
            bad = p.no_d || (p.d_opcode != (we ? 3'd0 : 3'd1)) || (p.d_param != 2'd0) ||
                  (p.d_size != {1'b0, size}) || p.d_source || p.d_denied || p.d_corrupt;
            r.err   = bad;
            r.rdata = p.no_d ? 32'h0 : p.d_data;
            if (p.no_d)             r.lat = 2 + p.a_delay + T;
            else if (p.d_delay < 0) r.lat = 2 + p.a_delay;
            else                    r.lat = 3 + p.a_delay + p.d_delay;
            exp_a_q.push_back(a);
            plan_q.push_back(p);
            slave_busy = 1'b1;
        end
        k = 0;
        while (!req_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (!req_ready) fail_now("req_ready_timeout", 32'(req_ready), 32'h1);
        req_we = we; req_addr = addr; req_size = size; req_wdata = wdata; req_wmask = wmask;
        req_valid = 1'b1;
        r.acc_cyc = cyc;
        if (expect_rsp) begin
            exp_rsp_q.push_back(r);
            n_rsp_exp++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((slave_busy || exp_rsp_q.size() != 0) && k < 300) begin
            @(posedge clk); #1; k++;
        end
        if (slave_busy || exp_rsp_q.size() != 0)
            fail_now("txn_done_timeout", 32'(exp_rsp_q.size()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input plan_t p);
        tl_d_valid = 1'b1;   tl_d_opcode = p.d_opcode; tl_d_param = p.d_param;
        tl_d_size = p.d_size; tl_d_source = p.d_source; tl_d_sink = 1'b0;
        tl_d_denied = p.d_denied; tl_d_corrupt = p.d_corrupt; tl_d_data = p.d_data;
    endtask

    // Scripted slave: follows the plan queued with each legal request.
    initial begin
        plan_t p;
        tl_a_ready = 1'b0; tl_d_valid = 1'b0; tl_d_opcode = '0; tl_d_param = '0;
        tl_d_size = '0; tl_d_source = 1'b0; tl_d_sink = 1'b0; tl_d_denied = 1'b0;
        tl_d_corrupt = 1'b0; tl_d_data = '0;
        forever begin
            @(posedge clk); #1;
            if (tl_a_valid && rst) begin
                if (plan_q.size() == 0) begin
                    fail_now("slave_unplanned_a", tl_a_address, 32'h0);
                    p = good_plan(1'b0, 2'd2, 0, 0, 32'h0);
                end else begin
                    p = plan_q.pop_front();
                end
                repeat (p.a_delay) begin @(posedge clk); #1; end
                tl_a_ready = 1'b1;
                if (!p.no_d && p.d_delay < 0) drive_d(p);
                @(posedge clk); #1;
                tl_a_ready = 1'b0;
                tl_d_valid = 1'b0;
                if (!p.no_d && p.d_delay >= 0) begin
                    repeat (p.d_delay) begin @(posedge clk); #1; end
                    drive_d(p);
                    @(posedge clk); #1;
                    tl_d_valid = 1'b0;
                end
                if (p.late) begin
                    repeat (p.late_gap) begin @(posedge clk); #1; end
                    drive_d(p);
                    @(posedge clk); #1;
                    tl_d_valid = 1'b0;
                end
                slave_busy = 1'b0;
            end
        end
    end

    // Monitor: channel A fields checked every cycle valid is high, responses popped on rsp_valid.
    initial begin
        a_exp_t   a;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (tl_a_valid) begin
                    if (exp_a_q.size() == 0) begin
                        fail_now("unexpected_a_valid", tl_a_address, 32'h0);
                    end else begin
                        a = exp_a_q[0];
                        check("a_opcode", 32'(tl_a_opcode), 32'(a.opcode));
                        check("a_size", 32'(tl_a_size), 32'(a.size));
                        check("a_address", tl_a_address, a.addr);
                        check("a_mask", 32'(tl_a_mask), 32'(a.mask));
                        check("a_data", tl_a_data, a.data);
                        check("a_param_src_corrupt",
                              32'({tl_a_param, tl_a_source, tl_a_corrupt}), 32'h0);
                        if (tl_a_ready) void'(exp_a_q.pop_front());
                    end
                end
                if (rsp_valid) begin
                    n_rsp++;
                    if (exp_rsp_q.size() == 0) begin
                        fail_now("unexpected_rsp_valid", 32'(rsp_err), 32'h0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_err", 32'(rsp_err), 32'(r.err));
                        check("rsp_rdata", rsp_rdata, r.rdata);
                        check("rsp_latency", 32'(cyc - r.acc_cyc), 32'(r.lat));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d, want finish", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        plan_t       p;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wmask;
        int          sel;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_wdata = '0; req_wmask = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_d_ready", 32'(tl_d_ready), 32'h0);
        check("rst_a_valid", 32'(tl_a_valid), 32'h0);
        check("rst_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_a_fields", 32'({tl_a_opcode, tl_a_size, tl_a_mask}), 32'h0);
        check("rst_a_addr_data", tl_a_address | tl_a_data, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready", 32'(req_ready), 32'h1);
        check("idle_d_ready", 32'(tl_d_ready), 32'h1);

        // Word write, slave acks one cycle after A.
        issue(1'b1, 32'h4, 2'd2, 32'h41, 4'hF, good_plan(1'b1, 2'd2, 0, 0, 32'h0), 1'b1);
        wait_done();
        // Byte write whose mask is exactly the aligned lane.
        issue(1'b1, 32'h6, 2'd0, 32'h00AB_0000, 4'b0100,
              good_plan(1'b1, 2'd0, 0, 0, 32'h0), 1'b1);
        wait_done();
        // Empty mask word write.
        issue(1'b1, 32'h8, 2'd2, 32'h1234_5678, 4'h0,
              good_plan(1'b1, 2'd2, 0, 1, 32'h0), 1'b1);
        wait_done();
        // Word read with data, then a denied read.
        issue(1'b0, 32'h0, 2'd2, 32'h0, 4'h0, good_plan(1'b0, 2'd2, 0, 0, 32'hF), 1'b1);
        wait_done();
        p = good_plan(1'b0, 2'd2, 1, 2, 32'hDEAD_BEEF);
        p.d_denied = 1'b1;
        issue(1'b0, 32'h10, 2'd2, 32'h0, 4'h0, p, 1'b1);
        wait_done();
        // Misaligned halfword and illegal size.
        issue(1'b0, 32'h3, 2'd1, 32'h0, 4'h0, p, 1'b1);
        wait_done();
        issue(1'b1, 32'h0, 2'd3, 32'h0, 4'hF, p, 1'b1);
        wait_done();
        // A and D handshake in the same cycle.
        issue(1'b0, 32'h22, 2'd1, 32'h0, 4'h0, good_plan(1'b0, 2'd1, 2, -1, 32'h5A5A_0000), 1'b1);
        wait_done();
        // Backpressured A, then no D: watchdog expires, late beat is drained.
        p = good_plan(1'b1, 2'd2, 5, 0, 32'h77);
        p.no_d = 1'b1; p.late = 1'b1; p.late_gap = T + 4;
        issue(1'b1, 32'h40, 2'd2, 32'hCAFE_F00D, 4'hF, p, 1'b1);
        wait_done();
        check("no_rsp_for_late_beat", 32'(n_rsp), 32'(n_rsp_exp));

        // Reset while waiting for D; late beat arrives after reset.
        p = good_plan(1'b0, 2'd2, 0, 0, 32'h99);
        p.no_d = 1'b1; p.late = 1'b1; p.late_gap = 6;
        issue(1'b0, 32'h80, 2'd2, 32'h0, 4'h0, p, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_a_valid", 32'(tl_a_valid), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_readies", 32'({req_ready, tl_d_ready}), 32'h0);
        check("mid_rst_a_addr", tl_a_address, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(req_ready), 32'h1);
        wait_done();
        check("no_rsp_after_reset", 32'(n_rsp), 32'(n_rsp_exp));
        issue(1'b0, 32'h84, 2'd2, 32'h0, 4'h0, good_plan(1'b0, 2'd2, 0, 0, 32'h1357_9BDF), 1'b1);
        wait_done();

        // Randomized traffic with occasional malformed D beats.
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 10);
            size = (sel < 10) ? 2'(sel % 3) : 2'd3;
            addr = $urandom;
            if ($urandom_range(0, 9) < 8) addr = addr & ~((32'h1 << size) - 32'h1);
            wmask = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            p = good_plan(we, size, $urandom_range(0, 3), $urandom_range(0, 4) - 1, $urandom);
            case ($urandom_range(0, 11))
                0: p.d_opcode  = p.d_opcode ^ 3'd1;
                1: p.d_param   = 2'($urandom_range(1, 3));
                2: p.d_size    = p.d_size + 3'd1;
                3: p.d_source  = 1'b1;
                4: p.d_denied  = 1'b1;
                5: p.d_corrupt = 1'b1;
                default: ;
            endcase
            issue(we, addr, size, $urandom, wmask, p, 1'b1);
            wait_done();
        end

        check("rsp_count", 32'(n_rsp), 32'(n_rsp_exp));
        check("a_queue_drained", 32'(exp_a_q.size()), 32'h0);
        check("plan_queue_drained", 32'(plan_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
